// File: rtl/neuron_feeder.sv
// neuron_feeder: buffers an upstream sample stream in a small FIFO and feeds
// one frame of NUM_WEIGHT samples into a neuron, then captures the neuron's
// output as the frame result and holds it until downstream accepts it.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready : upstream sample stream (s_ready = FIFO not full)
//   n_input/n_freeze/n_pause : drive the neuron's myinput/freeze/pause
//   n_out                  : the neuron's activated output
//   m_data/m_valid/m_ready : frame result handshake
//   busy                   : high in any state except IDLE
//   sample_cnt             : samples issued in the current frame
//
// All outputs come straight from flops; each is loaded with the value it
// must show in the cycle after the edge, computed from next-state terms.
module neuron_feeder #(
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [DATA_WIDTH-1:0]               n_input,
  output logic                                n_freeze,
  output logic                                n_pause,
  input  logic [DATA_WIDTH-1:0]               n_out,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                busy,
  output logic [$clog2(NUM_WEIGHT+1)-1:0]     sample_cnt
);

  localparam int unsigned CNT_W = $clog2(NUM_WEIGHT + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state, state_d;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr, rd_ptr_d;
  logic [OCC_W-1:0]        occ, occ_d;
  logic                    push, pop;
  logic [DATA_WIDTH-1:0]   head_d;

  logic [CNT_W-1:0]        cnt_d;
  logic [DATA_WIDTH-1:0]   m_data_d;
  logic                    m_valid_d;
  logic [DATA_WIDTH-1:0]   n_input_d;
  logic                    n_freeze_d;
  logic                    n_pause_d;
  logic                    s_ready_d;
  logic                    busy_d;

  // FIFO bookkeeping; pointers wrap naturally because FIFO_DEPTH is a power of two
  always_comb begin : fifo_next
    push     = s_valid && s_ready;
    pop      = (state == RUN) && (occ != '0);
    wr_ptr_d = wr_ptr + PTR_W'(push);
    rd_ptr_d = rd_ptr + PTR_W'(pop);
    occ_d    = occ + OCC_W'(push) - OCC_W'(pop);
    // A word written this edge into the slot that becomes the head is not yet in mem
    head_d   = (push && (wr_ptr == rd_ptr_d)) ? s_data : mem[rd_ptr_d];
  end

  // Sample storage; contents are only meaningful under the occupancy count
  always_ff @(posedge clk) begin : fifo_mem
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Frame sequencing and next values of the registered outputs
  always_comb begin : fsm_next
    state_d   = state;
    cnt_d     = sample_cnt;
    m_data_d  = m_data;
    m_valid_d = m_valid;

    unique case (state)
      IDLE: begin
        if (occ != '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pop) begin
          cnt_d = sample_cnt + CNT_W'(1);
          if (sample_cnt == CNT_W'(NUM_WEIGHT - 1)) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        m_data_d  = n_out;
        m_valid_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    n_freeze_d = (state_d != RUN);
    n_pause_d  = (state_d == RUN) && (occ_d == '0);
    s_ready_d  = (occ_d != OCC_W'(FIFO_DEPTH));
    busy_d     = (state_d != IDLE);

    // While paused in RUN the last issued sample stays on the neuron input
    if (occ_d != '0) begin
      n_input_d = head_d;
    end else if (state_d == RUN) begin
      n_input_d = n_input;
    end else begin
      n_input_d = '0;
    end
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      sample_cnt <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      n_input    <= '0;
      n_freeze   <= 1'b1;
      n_pause    <= 1'b0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      occ        <= occ_d;
      sample_cnt <= cnt_d;
      m_data     <= m_data_d;
      m_valid    <= m_valid_d;
      n_input    <= n_input_d;
      n_freeze   <= n_freeze_d;
      n_pause    <= n_pause_d;
      s_ready    <= s_ready_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
module tb_neuron_feeder;

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] n_input;
  logic          n_freeze;
  logic          n_pause;
  logic [DW-1:0] n_out;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic [2:0]    sample_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_feeder #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .n_input(n_input), .n_freeze(n_freeze), .n_pause(n_pause), .n_out(n_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .sample_cnt(sample_cnt)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " n_freeze"}, 32'(n_freeze), 1);
    chk({tag, " n_pause"}, 32'(n_pause), 0);
    chk({tag, " n_input"}, 32'(n_input), 0);
    chk({tag, " m_valid"}, 32'(m_valid), 0);
    chk({tag, " m_data"}, 32'(m_data), 0);
    chk({tag, " sample_cnt"}, 32'(sample_cnt), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " s_ready"}, 32'(s_ready), 1);
  endtask

  // Frame-level reference: a sample queue, the frame phase, samples issued,
  // the last sample given to the neuron and the held result.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_CAP = 2, PH_DONE = 3;
  logic [DW-1:0] mq[$];
  int            m_phase;
  int            m_issued;
  logic [DW-1:0] m_last;
  logic [DW-1:0] m_res;
  bit            m_rvalid;

  task automatic model_reset();
    mq.delete();
    m_phase = PH_IDLE; m_issued = 0; m_last = '0; m_res = '0; m_rvalid = 0;
  endtask

  task automatic model_edge(input logic sv, input logic [DW-1:0] sd,
                            input logic mr, input logic [DW-1:0] no);
    int nph;
    bit accept;
    bit have;
    nph    = m_phase;
    accept = sv && (mq.size() < FD);
    have   = (mq.size() > 0);
    case (m_phase)
      PH_IDLE: if (have) nph = PH_RUN;
      PH_RUN: if (have) begin
        m_last = mq.pop_front();
        m_issued++;
        if (m_issued == NW) nph = PH_CAP;
      end
      PH_CAP: begin m_res = no; m_rvalid = 1; nph = PH_DONE; end
      default: if (mr) begin m_rvalid = 0; m_issued = 0; nph = PH_IDLE; end
    endcase
    if (accept) mq.push_back(sd);
    m_phase = nph;
  endtask

  task automatic model_compare();
    logic [DW-1:0] e_in;
    if (mq.size() > 0) e_in = mq[0];
    else if (m_phase == PH_RUN) e_in = m_last;
    else e_in = '0;
    chk("n_input", 32'(n_input), 32'(e_in));
    chk("n_freeze", 32'(n_freeze), 32'(m_phase != PH_RUN));
    chk("n_pause", 32'(n_pause), 32'((m_phase == PH_RUN) && (mq.size() == 0)));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < FD));
    chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    chk("sample_cnt", 32'(sample_cnt), 32'(m_issued));
    chk("m_valid", 32'(m_valid), 32'(m_rvalid));
    if (m_rvalid) chk("m_data", 32'(m_data), 32'(m_res));
  endtask

  // One clock: compare against the model, drive inputs, advance both sides
  task automatic step(input logic sv, input logic [DW-1:0] sd,
                      input logic mr, input logic [DW-1:0] no);
    model_compare();
    s_valid = sv; s_data = sd; m_ready = mr; n_out = no;
    @(posedge clk);
    model_edge(sv, sd, mr, no);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; n_out = '0;
    @(posedge clk); #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic [DW-1:0] no;
    logic [DW-1:0] nin;
    logic          pause;
    logic          freeze;
    logic          mv;
    logic [DW-1:0] md;
    int            cnt;
    logic          srdy;
    logic          bsy;
  } vec_t;

  vec_t tq[$];

  task automatic add(input logic sv, input int sd, input logic mr, input int no,
                     input int nin, input logic pause, input logic freeze, input logic mv,
                     input int md, input int cnt, input logic srdy, input logic bsy);
    vec_t v;
    v.sv = sv; v.sd = DW'(sd); v.mr = mr; v.no = DW'(no);
    v.nin = DW'(nin); v.pause = pause; v.freeze = freeze; v.mv = mv;
    v.md = DW'(md); v.cnt = cnt; v.srdy = srdy; v.bsy = bsy;
    tq.push_back(v);
  endtask

  initial begin
    int paused;
    int p_push;
    int p_rdy;

    do_reset();

    // Full frame 1..4, capture, then a held result while the FIFO fills up.
    // Row = inputs for this cycle | outputs expected before the edge.
    //   sv sd    mr no         nin   pz fz mv md      cnt rdy bsy
    add(1, 1,    0, 0,         0,    0, 1, 0, 0,     0,  1,  0);
    add(1, 2,    0, 0,         1,    0, 1, 0, 0,     0,  1,  0);
    add(1, 3,    0, 0,         1,    0, 0, 0, 0,     0,  1,  1);
    add(1, 4,    0, 0,         2,    0, 0, 0, 0,     1,  1,  1);
    add(0, 0,    0, 0,         3,    0, 0, 0, 0,     2,  1,  1);
    add(0, 0,    0, 'h1234,    4,    0, 0, 0, 0,     3,  1,  1);
    add(1, 5,    0, 'h0abc,    0,    0, 1, 0, 0,     4,  1,  1);
    add(1, 6,    0, 'hffff,    5,    0, 1, 1, 'habc, 4,  1,  1);
    add(1, 7,    0, 0,         5,    0, 1, 1, 'habc, 4,  1,  1);
    add(1, 8,    0, 0,         5,    0, 1, 1, 'habc, 4,  1,  1);
    add(1, 9,    0, 0,         5,    0, 1, 1, 'habc, 4,  0,  1);
    add(0, 0,    0, 0,         5,    0, 1, 1, 'habc, 4,  0,  1);
    add(0, 0,    1, 0,         5,    0, 1, 1, 'habc, 4,  0,  1);
    add(0, 0,    0, 0,         5,    0, 1, 0, 'habc, 0,  0,  0);
    add(0, 0,    0, 0,         5,    0, 0, 0, 'habc, 0,  0,  1);
    add(0, 0,    0, 0,         6,    0, 0, 0, 'habc, 1,  1,  1);

    foreach (tq[i]) begin
      chk($sformatf("t%0d n_input", i), 32'(n_input), 32'(tq[i].nin));
      chk($sformatf("t%0d n_pause", i), 32'(n_pause), 32'(tq[i].pause));
      chk($sformatf("t%0d n_freeze", i), 32'(n_freeze), 32'(tq[i].freeze));
      chk($sformatf("t%0d m_valid", i), 32'(m_valid), 32'(tq[i].mv));
      chk($sformatf("t%0d m_data", i), 32'(m_data), 32'(tq[i].md));
      chk($sformatf("t%0d sample_cnt", i), 32'(sample_cnt), 32'(tq[i].cnt));
      chk($sformatf("t%0d s_ready", i), 32'(s_ready), 32'(tq[i].srdy));
      chk($sformatf("t%0d busy", i), 32'(busy), 32'(tq[i].bsy));
      s_valid = tq[i].sv; s_data = tq[i].sd; m_ready = tq[i].mr; n_out = tq[i].no;
      @(posedge clk); #1;
    end

    // Input gap of 3 cycles after samples 1,2: one sample is still buffered
    // when the gap opens, so the neuron sees 2 paused cycles holding sample 2.
    do_reset();
    paused = 0;
    for (int k = 0; k < 12; k++) begin
      if (n_pause) begin
        paused++;
        chk("gap n_input held", 32'(n_input), 2);
        chk("gap sample_cnt held", 32'(sample_cnt), 2);
      end
      case (k)
        0: step(1, 1, 0, 0);
        1: step(1, 2, 0, 0);
        5: step(1, 3, 0, 0);
        6: step(1, 4, 0, 16'h0777);
        default: step(0, 0, 1, 16'h0777);
      endcase
    end
    chk("gap pause cycles", 32'(paused), 2);

    // Reset in the middle of a frame, two samples issued and one buffered
    do_reset();
    step(1, 16'h11, 0, 0);
    step(1, 16'h22, 0, 0);
    step(1, 16'h33, 0, 0);
    step(0, 0, 0, 0);
    chk("pre-reset sample_cnt", 32'(sample_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset n_freeze", 32'(n_freeze), 1);
    chk("post-reset s_ready", 32'(s_ready), 1);
    chk("post-reset n_input", 32'(n_input), 0);
    model_reset();
    for (int k = 0; k < 4; k++) step(1, DW'(16'h100 + k), 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 16'h0555);

    // Randomised traffic against the reference, with varied push and accept rates
    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin p_push = 90; p_rdy = 80; end
        1: begin p_push = 50; p_rdy = 30; end
        2: begin p_push = 20; p_rdy = 100; end
        3: begin p_push = 100; p_rdy = 10; end
        4: begin p_push = 70; p_rdy = 60; end
        default: begin p_push = 30; p_rdy = 50; end
      endcase
      for (int k = 0; k < 500; k++) begin
        step($urandom_range(0, 99) < p_push, DW'($urandom),
             $urandom_range(0, 99) < p_rdy, DW'($urandom));
      end
    end
    model_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
